// File: rtl/midi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : midi_pkg
//  Description : Shared MIDI constants, FSM state and event-class types for
//                the voice allocator and the note-to-period lookup.
//  Revision    : 1.0  initial release
// ============================================================================
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'b1001;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'b1000;
    localparam logic [6:0] NOTE_MIDDLE_C = 7'd60;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef enum logic {
        EV_ON  = 1'b0,
        EV_OFF = 1'b1
    } ev_class_t;

endpackage
`default_nettype wire

// File: rtl/midi_voice_allocator_if.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_allocator_if
//  Description : Event handshake and voice/update bus between the MIDI
//                parser (master) and the voice allocator (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface midi_voice_allocator_if #(
    parameter int NUM_VOICES = 4
);
    localparam int IDX_W = $clog2(NUM_VOICES);

    logic [3:0]              status;
    logic [7:0]              data_byte1;
    logic [7:0]              data_byte2;
    logic                    valid_in;
    logic                    ready_out;
    logic [NUM_VOICES-1:0]   voice_on;
    logic [7*NUM_VOICES-1:0] voice_note;
    logic                    update_valid;
    logic [IDX_W-1:0]        update_voice;
    logic                    update_hit;
    logic                    update_stolen;

    modport master (
        output status, data_byte1, data_byte2, valid_in,
        input  ready_out, voice_on, voice_note,
        input  update_valid, update_voice, update_hit, update_stolen
    );

    modport slave (
        input  status, data_byte1, data_byte2, valid_in,
        output ready_out, voice_on, voice_note,
        output update_valid, update_voice, update_hit, update_stolen
    );

endinterface
`default_nettype wire

// File: rtl/midi_voice_slot.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_slot
//  Description : One playback slot: gate, note number and saturating age.
//  Revision    : 1.0  initial release
// ============================================================================
module midi_voice_slot
    import midi_pkg::*;
#(
    parameter int AGE_W = 8
) (
    input  wire logic             clk_in,
    input  wire logic             rst_n_in,
    input  wire logic             assign_en,
    input  wire logic             release_en,
    input  wire logic             age_tick,
    input  wire logic [6:0]       new_note,
    output logic                  gate,
    output logic [6:0]            note,
    output logic [AGE_W-1:0]      age
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    // Slot state: assignment wins, otherwise release and ageing of active slots
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gate <= 1'b0;
            note <= NOTE_MIDDLE_C;
            age  <= '0;
        end else if (assign_en) begin
            gate <= 1'b1;
            note <= new_note;
            age  <= '0;
        end else begin
            if (release_en) begin
                gate <= 1'b0;
            end
            // Inactive slots hold their age; it only ranks active voices
            if (age_tick && gate && (age != AGE_MAX)) begin
                age <= age + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : midi_voice_allocator
//  Description : Polyphonic voice scheduler. Scans all slots one per cycle,
//                then retriggers, takes a free slot, or steals the oldest.
//  Revision    : 1.0  initial release
// ============================================================================
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 8
) (
    input  wire logic             clk_in,
    input  wire logic             rst_n_in,
    midi_voice_allocator_if.slave bus
);

    localparam int               IDX_W    = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [IDX_W-1:0]        r_scan_idx;
    logic [6:0]              r_note;
    ev_class_t               r_class;

    logic                    r_match_found;
    logic [IDX_W-1:0]        r_match_idx;
    logic                    r_free_found;
    logic [IDX_W-1:0]        r_free_idx;
    logic                    r_old_found;
    logic [IDX_W-1:0]        r_old_idx;
    logic [AGE_W-1:0]        r_old_age;

    logic                    r_update_valid;
    logic [IDX_W-1:0]        r_update_voice;
    logic                    r_update_hit;
    logic                    r_update_stolen;

    logic                    w_accept;
    logic                    w_is_on;
    logic                    w_is_off;
    logic                    w_commit;
    logic [IDX_W-1:0]        w_upd_voice;
    logic                    w_upd_hit;
    logic                    w_upd_stolen;
    logic [NUM_VOICES-1:0]   w_assign_en;
    logic [NUM_VOICES-1:0]   w_release_en;
    logic [NUM_VOICES-1:0]   w_age_tick;

    logic [NUM_VOICES-1:0]   w_gate;
    logic [6:0]              w_slot_note [NUM_VOICES];
    logic [AGE_W-1:0]        w_age       [NUM_VOICES];
    logic [7*NUM_VOICES-1:0] w_note_flat;

    logic                    w_cur_gate;
    logic [6:0]              w_cur_note;
    logic [AGE_W-1:0]        w_cur_age;
    logic                    w_unused_msb;

    assign w_unused_msb = bus.data_byte1[7];

    assign w_accept = bus.valid_in && (r_state == IDLE);
    assign w_is_on  = (bus.status == MIDI_NOTE_ON) && (bus.data_byte2 != 8'd0);
    assign w_is_off = (bus.status == MIDI_NOTE_OFF) ||
                      ((bus.status == MIDI_NOTE_ON) && (bus.data_byte2 == 8'd0));

    assign w_cur_gate = w_gate[r_scan_idx];
    assign w_cur_note = w_slot_note[r_scan_idx];
    assign w_cur_age  = w_age[r_scan_idx];

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: non-note events are swallowed without leaving IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept && (w_is_on || w_is_off)) w_next_state = SCAN;
            SCAN:    if (r_scan_idx == LAST_IDX)            w_next_state = COMMIT;
            COMMIT:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output logic: handshake plus the commit decision and per-slot controls
    always_comb begin
        bus.ready_out = (r_state == IDLE);
        w_commit      = (r_state == COMMIT);
        w_upd_voice   = '0;
        w_upd_hit     = 1'b0;
        w_upd_stolen  = 1'b0;
        w_assign_en   = '0;
        w_release_en  = '0;
        w_age_tick    = '0;
        if (r_class == EV_ON) begin
            w_upd_hit = 1'b1;
            if (r_match_found) begin
                w_upd_voice = r_match_idx;
            end else if (r_free_found) begin
                w_upd_voice = r_free_idx;
            end else begin
                w_upd_voice  = r_old_idx;
                w_upd_stolen = 1'b1;
            end
        end else if (r_match_found) begin
            w_upd_voice = r_match_idx;
            w_upd_hit   = 1'b1;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (w_commit && (r_class == EV_ON)) begin
                if (w_upd_voice == IDX_W'(i)) w_assign_en[i] = 1'b1;
                else                          w_age_tick[i]  = 1'b1;
            end
            if (w_commit && (r_class == EV_OFF) && w_upd_hit && (w_upd_voice == IDX_W'(i))) begin
                w_release_en[i] = 1'b1;
            end
        end
    end

    // Event latch and candidate tracking; strict '>' keeps the lowest index on ties
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_scan_idx    <= '0;
            r_note        <= NOTE_MIDDLE_C;
            r_class       <= EV_OFF;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_old_found   <= 1'b0;
            r_old_idx     <= '0;
            r_old_age     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_note        <= bus.data_byte1[6:0];
                        r_class       <= w_is_on ? EV_ON : EV_OFF;
                        r_scan_idx    <= '0;
                        r_match_found <= 1'b0;
                        r_free_found  <= 1'b0;
                        r_old_found   <= 1'b0;
                        r_old_age     <= '0;
                    end
                end
                SCAN: begin
                    if (w_cur_gate && (w_cur_note == r_note) && !r_match_found) begin
                        r_match_found <= 1'b1;
                        r_match_idx   <= r_scan_idx;
                    end
                    if (!w_cur_gate && !r_free_found) begin
                        r_free_found <= 1'b1;
                        r_free_idx   <= r_scan_idx;
                    end
                    if (w_cur_gate && (!r_old_found || (w_cur_age > r_old_age))) begin
                        r_old_found <= 1'b1;
                        r_old_idx   <= r_scan_idx;
                        r_old_age   <= w_cur_age;
                    end
                    r_scan_idx <= r_scan_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Update report registers; fields hold between commits
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_update_valid  <= 1'b0;
            r_update_voice  <= '0;
            r_update_hit    <= 1'b0;
            r_update_stolen <= 1'b0;
        end else begin
            r_update_valid <= w_commit;
            if (w_commit) begin
                r_update_voice  <= w_upd_voice;
                r_update_hit    <= w_upd_hit;
                r_update_stolen <= w_upd_stolen;
            end
        end
    end

    assign bus.update_valid  = r_update_valid;
    assign bus.update_voice  = r_update_voice;
    assign bus.update_hit    = r_update_hit;
    assign bus.update_stolen = r_update_stolen;
    assign bus.voice_on      = w_gate;
    assign bus.voice_note    = w_note_flat;

    generate
        for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_slot
            midi_voice_slot #(
                .AGE_W (AGE_W)
            ) u_slot (
                .clk_in     (clk_in),
                .rst_n_in   (rst_n_in),
                .assign_en  (w_assign_en[gi]),
                .release_en (w_release_en[gi]),
                .age_tick   (w_age_tick[gi]),
                .new_note   (r_note),
                .gate       (w_gate[gi]),
                .note       (w_slot_note[gi]),
                .age        (w_age[gi])
            );
            assign w_note_flat[7*gi +: 7] = w_slot_note[gi];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_midi_voice_allocator
//  Description : Scoreboard bench for the voice allocator with a behavioural
//                slot model and randomized MIDI event traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_midi_voice_allocator;

    localparam int NV      = 4;
    localparam int AGE_MAX = 255;
    localparam int LAT     = NV + 1;   // edges from acceptance edge to visible commit

    typedef struct {
        int          voice;
        bit          hit;
        bit          stolen;
        logic [3:0]  von;
        logic [27:0] notes;
        int          due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    int   upd_seen = 0;
    int   last_voice = 0;
    bit   last_hit = 1'b0;
    bit   last_stolen = 1'b0;
    exp_t q[$];

    int m_gate [NV];
    int m_note [NV];
    int m_age  [NV];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    midi_voice_allocator_if #(.NUM_VOICES(NV)) bus ();

    midi_voice_allocator #(
        .NUM_VOICES (NV),
        .AGE_W      (8)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_gate[i] = 0;
            m_note[i] = 60;
            m_age[i]  = 0;
        end
    endtask

    // Reference behaviour: classify the event, pick a voice, update slot table
    task automatic model_apply(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2,
                               input int acc);
        exp_t e;
        int   nt, match, free, oldest, chosen;
        bit   is_on, is_off;
        nt     = int'(b1[6:0]);
        is_on  = (st == 4'b1001) && (b2 != 0);
        is_off = (st == 4'b1000) || ((st == 4'b1001) && (b2 == 0));
        if (!is_on && !is_off) return;
        match = -1; free = -1; oldest = -1;
        for (int i = 0; i < NV; i++) begin
            if (match < 0 && m_gate[i] != 0 && m_note[i] == nt) match = i;
            if (free < 0 && m_gate[i] == 0) free = i;
            if (m_gate[i] != 0 && (oldest < 0 || m_age[i] > m_age[oldest])) oldest = i;
        end
        e.stolen = 1'b0;
        if (is_on) begin
            if (match >= 0)     chosen = match;
            else if (free >= 0) chosen = free;
            else begin chosen = oldest; e.stolen = 1'b1; end
            for (int i = 0; i < NV; i++) begin
                if (i != chosen && m_gate[i] != 0 && m_age[i] < AGE_MAX) m_age[i]++;
            end
            m_gate[chosen] = 1; m_note[chosen] = nt; m_age[chosen] = 0;
            e.voice = chosen; e.hit = 1'b1;
        end else if (match >= 0) begin
            m_gate[match] = 0;
            e.voice = match; e.hit = 1'b1;
        end else begin
            e.voice = 0; e.hit = 1'b0;
        end
        for (int i = 0; i < NV; i++) begin
            e.von[i] = (m_gate[i] != 0);
            e.notes[7*i +: 7] = m_note[i][6:0];
        end
        e.due = acc + LAT;
        q.push_back(e);
    endtask

    // Drive one event and wait (bounded) for its acceptance edge
    task automatic send(input logic [3:0] st, input logic [7:0] b1, input logic [7:0] b2,
                        input bit hold, output int acc);
        int n = 0;
        bus.status = st; bus.data_byte1 = b1; bus.data_byte2 = b2; bus.valid_in = 1'b1;
        while (bus.ready_out !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) begin
            checks++; errors++;
            $display("FAIL accept_timeout: actual=ready low required=accepted within 60 cycles");
            bus.valid_in = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        model_apply(st, b1, b2, acc);
        if (!hold) bus.valid_in = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 60) begin @(negedge clk); n++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL commit_timeout: actual=%0d pending required=0 pending", q.size());
            q.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"},  32'(bus.ready_out), 32'd1);
        check({tag, "_uvalid"}, 32'(bus.update_valid), 32'd0);
        check({tag, "_uvoice"}, 32'(bus.update_voice), 32'd0);
        check({tag, "_uhit"},   32'(bus.update_hit), 32'd0);
        check({tag, "_ustol"},  32'(bus.update_stolen), 32'd0);
        check({tag, "_von"},    32'(bus.voice_on), 32'd0);
        check({tag, "_notes"},  32'(bus.voice_note), 32'({4{7'd60}}));
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        last_voice = 0; last_hit = 1'b0; last_stolen = 1'b0;
        @(posedge clk); #2;
        check_reset_vals("rst");
        rst_n = 1'b1;
    endtask

    // Monitor: pop and compare on every update strobe; check hold otherwise
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.update_valid === 1'b1) begin
                upd_seen++;
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_update: actual=update_valid 1 required=no pending event");
                end else begin
                    e = q.pop_front();
                    check("upd_voice",  32'(bus.update_voice), 32'(e.voice));
                    check("upd_hit",    32'(bus.update_hit), 32'(e.hit));
                    check("upd_stolen", 32'(bus.update_stolen), 32'(e.stolen));
                    check("voice_on",   32'(bus.voice_on), 32'(e.von));
                    check("voice_note", 32'(bus.voice_note), 32'(e.notes));
                    check("latency",    32'(cyc), 32'(e.due));
                    check("ready_with_update", 32'(bus.ready_out), 32'd1);
                    last_voice = e.voice; last_hit = e.hit; last_stolen = e.stolen;
                end
            end else if (rst_n) begin
                check("hold_fields", 32'({bus.update_voice, bus.update_hit, bus.update_stolen}),
                      32'({2'(last_voice), last_hit, last_stolen}));
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: actual=still running required=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int a1, a2, seen0, r, n_ev;
        bit hold;
        logic [3:0] st;
        logic [7:0] b1, b2;
        bus.status = 4'd0; bus.data_byte1 = 8'd0; bus.data_byte2 = 8'd0; bus.valid_in = 1'b0;
        model_reset();
        do_reset();

        // First Note On: busy for 5 cycles, visible in cycle 6 on voice 0
        send(4'b1001, 8'd64, 8'd100, 1'b0, a1);
        for (int k = 1; k <= NV + 1; k++) begin
            @(negedge clk);
            check("busy_ready", 32'(bus.ready_out), 32'd0);
        end
        @(negedge clk);
        check("first_uvalid", 32'(bus.update_valid), 32'd1);
        check("first_von", 32'(bus.voice_on), 32'b0001);
        check("first_note0", 32'(bus.voice_note[6:0]), 32'd64);
        wait_done();

        // Fill all voices then steal the oldest
        do_reset();
        send(4'b1001, 8'd60, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd62, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd64, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd65, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd67, 8'd90, 1'b0, a1); wait_done();
        check("steal_flag", 32'(bus.update_stolen), 32'd1);
        check("steal_voice", 32'(bus.update_voice), 32'd0);
        check("steal_note0", 32'(bus.voice_note[6:0]), 32'd67);

        // Retrigger resets the voice's age; voice 1 becomes the oldest
        do_reset();
        send(4'b1001, 8'd60, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd62, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd60, 8'd70, 1'b0, a1); wait_done();
        check("retrig_voice", 32'(bus.update_voice), 32'd0);
        check("retrig_stolen", 32'(bus.update_stolen), 32'd0);
        send(4'b1001, 8'd64, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd65, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd67, 8'd90, 1'b0, a1); wait_done();
        check("aged_steal_voice", 32'(bus.update_voice), 32'd1);

        // Velocity-0 release, then a Note Off that matches nothing
        do_reset();
        send(4'b1001, 8'd60, 8'd90, 1'b0, a1); wait_done();
        send(4'b1001, 8'd60, 8'd0, 1'b0, a1);  wait_done();
        check("rel_von", 32'(bus.voice_on), 32'd0);
        check("rel_note0", 32'(bus.voice_note[6:0]), 32'd60);
        send(4'b1000, 8'd70, 8'd40, 1'b0, a1); wait_done();
        check("miss_hit", 32'(bus.update_hit), 32'd0);
        check("miss_voice", 32'(bus.update_voice), 32'd0);

        // Non-note status is swallowed
        seen0 = upd_seen;
        send(4'b1011, 8'd7, 8'd1, 1'b0, a1);
        for (int k = 0; k < NV + 4; k++) begin
            @(negedge clk);
            check("discard_ready", 32'(bus.ready_out), 32'd1);
        end
        check("discard_no_update", 32'(upd_seen), 32'(seen0));

        // Back-to-back with valid held
        send(4'b1001, 8'd50, 8'd90, 1'b1, a1);
        send(4'b1001, 8'd52, 8'd80, 1'b0, a2);
        check("b2b_spacing", 32'(a2 - a1), 32'(NV + 2));
        wait_done();

        // Reset in cycle 3 of a scan aborts the event
        send(4'b1001, 8'd72, 8'd90, 1'b0, a1);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        q.delete(); model_reset();
        last_voice = 0; last_hit = 1'b0; last_stolen = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(posedge clk); #2;
        rst_n = 1'b1;
        seen0 = upd_seen;
        repeat (NV + 6) @(negedge clk);
        check("midrst_no_commit", 32'(upd_seen), 32'(seen0));
        check("midrst_von", 32'(bus.voice_on), 32'd0);

        // Randomized traffic against the model
        n_ev = 120;
        for (int k = 0; k < n_ev; k++) begin
            r  = $urandom_range(0, 9);
            b1 = {1'($urandom_range(0, 1)), 7'(60 + $urandom_range(0, 7))};
            b2 = 8'($urandom_range(1, 127));
            if (r <= 4)      st = 4'b1001;
            else if (r <= 7) st = 4'b1000;
            else if (r == 8) begin st = 4'($urandom_range(10, 15)); end
            else begin st = 4'b1001; b2 = 8'd0; end
            hold = ($urandom_range(0, 3) == 0) && (k != n_ev - 1);
            send(st, b1, b2, hold, a1);
            if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        bus.valid_in = 1'b0;
        wait_done();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
